program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 176 +++++++++++++++++
 tb/tb_program_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: receives a framed byte stream {N, N x {addr, data}[, checksum]},
// issues one program-memory write per record, waits for load_done and then
// raises start_execution. Define LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte covering every preceding frame byte.
module program_loader #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 8,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic [DATA_WIDTH-1:0] prog_data_in,
  output logic                  prog_write_enable,
  input  logic                  load_done,
  output logic                  start_execution,
  output logic                  busy,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    WAIT_DONE,
    START,
    ERROR
  } state_e;

`ifdef LOADER_CHECKSUM_EN
  localparam state_e FRAME_END = CHECK;
`else
  localparam state_e FRAME_END = WAIT_DONE;
`endif

  localparam logic [7:0] TIMEOUT_C = 8'(DONE_TIMEOUT);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] rec_cnt_q, rec_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] prog_addr_q, prog_addr_d;
  logic [DATA_WIDTH-1:0] prog_data_q, prog_data_d;
  logic [7:0]            tmo_q, tmo_d;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rec_cnt_q   <= '0;
      addr_q      <= '0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      tmo_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rec_cnt_q   <= rec_cnt_d;
      addr_q      <= addr_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      tmo_q       <= tmo_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Next-state, datapath updates and state-decoded outputs
  always_comb begin
    state_d           = state_q;
    rec_cnt_d         = rec_cnt_q;
    addr_d            = addr_q;
    prog_addr_d       = prog_addr_q;
    prog_data_d       = prog_data_q;
    tmo_d             = '0;
`ifdef LOADER_CHECKSUM_EN
    csum_d            = csum_q;
`endif
    in_ready          = 1'b0;
    prog_write_enable = 1'b0;
    start_execution   = 1'b0;
    busy              = 1'b1;
    error             = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          rec_cnt_d = in_data;
`ifdef LOADER_CHECKSUM_EN
          csum_d    = in_data;
`endif
          state_d   = (in_data != '0) ? ADDR : FRAME_END;
        end
      end
      ADDR: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if ((in_data >> ADDR_WIDTH) != '0) begin
            state_d = ERROR;
          end else begin
            addr_d  = in_data[ADDR_WIDTH-1:0];
            state_d = DATA;
          end
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          // Output registers are loaded here so they are already valid during
          // the WRITE strobe and keep the last written pair afterwards.
          prog_addr_d = addr_q;
          prog_data_d = in_data;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        prog_write_enable = 1'b1;
        rec_cnt_d         = rec_cnt_q - DATA_WIDTH'(1);
        state_d           = (rec_cnt_q != DATA_WIDTH'(1)) ? ADDR : FRAME_END;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = (in_data == csum_q) ? WAIT_DONE : ERROR;
        end
      end
`endif
      WAIT_DONE: begin
        if (load_done) begin
          state_d = START;
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_d == TIMEOUT_C) begin
            state_d = ERROR;
          end
        end
      end
      START: begin
        start_execution = 1'b1;
        busy            = 1'b0;
      end
      ERROR: begin
        error = 1'b1;
        busy  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign prog_addr    = prog_addr_q;
  assign prog_data_in = prog_data_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and randomized frames checked against a
// frame-level reference model (expected writes, consumed bytes, outcome).
module tb_program_loader;

  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int TMO = 255;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data_in;
  logic          prog_write_enable;
  logic          load_done;
  logic          start_execution;
  logic          busy;
  logic          error;

  program_loader #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .DONE_TIMEOUT(TMO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .prog_addr        (prog_addr),
    .prog_data_in     (prog_data_in),
    .prog_write_enable(prog_write_enable),
    .load_done        (load_done),
    .start_execution  (start_execution),
    .busy             (busy),
    .error            (error)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW+DW-1:0] obs_q[$];
  logic [AW+DW-1:0] exp_w[$];
  logic [7:0]       frame_q[$];
  bit               exp_err;
  int               exp_cons;
  int               n_cons;

  // Capture every write strobe as {addr, data}
  always @(negedge clock) begin
    if (prog_write_enable) obs_q.push_back({prog_addr, prog_data_in});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; load_done = 1'b0; in_data = '0;
    @(negedge clock);
    obs_q.delete();
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_start"}, 32'(start_execution), 0);
    check({tag, "_pwe"}, 32'(prog_write_enable), 0);
    check({tag, "_addr"}, 32'(prog_addr), 0);
    check({tag, "_data"}, 32'(prog_data_in), 0);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic append_cs(input bit corrupt);
    logic [7:0] x;
    x = '0;
    foreach (frame_q[i]) x ^= frame_q[i];
    if (corrupt) x ^= 8'($urandom_range(1, 255));
    frame_q.push_back(x);
  endtask
`endif

  // Reference: walk the frame by its rules and derive writes/consumption/outcome
  task automatic model_frame();
    int n, idx, cons;
    logic [7:0] a, d;
    exp_w.delete();
    exp_err = 1'b0;
    n    = int'(frame_q[0]);
    cons = 1;
    idx  = 1;
    for (int r = 0; r < n && !exp_err; r++) begin
      a = frame_q[idx];
      cons++;
      if (int'(a) >= (1 << AW)) begin
        exp_err = 1'b1;
      end else begin
        d = frame_q[idx + 1];
        cons++;
        exp_w.push_back({a[AW-1:0], d});
        idx += 2;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (!exp_err) begin
      a = '0;
      for (int j = 0; j < idx; j++) a ^= frame_q[j];
      cons++;
      if (frame_q[idx] != a) exp_err = 1'b1;
    end
`endif
    exp_cons = cons;
  endtask

  task automatic build_random();
    int n;
    logic [7:0] a;
    frame_q.delete();
    n = $urandom_range(0, 6);
    frame_q.push_back(8'(n));
    for (int r = 0; r < n; r++) begin
      a = ($urandom_range(0, 99) < 8) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
      frame_q.push_back(a);
      frame_q.push_back(8'($urandom));
    end
`ifdef LOADER_CHECKSUM_EN
    append_cs($urandom_range(0, 4) == 0);
`endif
    model_frame();
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle per byte, 2 random 0..2 idle cycles
  task automatic send_frame(input int gap_mode);
    bit acc, rdy;
    int g;
    n_cons = 0;
    foreach (frame_q[i]) begin
      g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
      repeat (g) begin
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      acc = 1'b0;
      for (int w = 0; w < 8 && !acc; w++) begin
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = frame_q[i];
        rdy      = in_ready;
        @(posedge clock);
        if (rdy) acc = 1'b1;
      end
      if (!acc) break;
      n_cons++;
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic settle();
    for (int w = 0; w < 6; w++) begin
      if (error || (busy && !in_ready && !prog_write_enable)) break;
      @(negedge clock);
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_consumed"}, 32'(n_cons), 32'(exp_cons));
    check({tag, "_nwrites"}, 32'(obs_q.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) begin
      if (i < obs_q.size()) check({tag, "_write"}, 32'(obs_q[i]), 32'(exp_w[i]));
    end
  endtask

  task automatic finish_frame(input string tag, input int done_delay);
    settle();
    check_writes(tag);
    if (exp_err) begin
      check({tag, "_error"}, 32'(error), 1);
      check({tag, "_in_ready"}, 32'(in_ready), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_start"}, 32'(start_execution), 0);
    end else begin
      check({tag, "_wait_busy"}, 32'(busy), 1);
      check({tag, "_wait_ready"}, 32'(in_ready), 0);
      check({tag, "_wait_error"}, 32'(error), 0);
      repeat (done_delay) @(negedge clock);
      check({tag, "_prestart"}, 32'(start_execution), 0);
      load_done = 1'b1;
      @(negedge clock);
      load_done = 1'b0;
      check({tag, "_start"}, 32'(start_execution), 1);
      check({tag, "_start_busy"}, 32'(busy), 0);
      // A byte offered after start must not be taken and start stays high
      in_valid = 1'b1;
      in_data  = 8'h01;
      repeat (2) @(negedge clock);
      check({tag, "_start_ready"}, 32'(in_ready), 0);
      check({tag, "_start_hold"}, 32'(start_execution), 1);
      check({tag, "_start_noerr"}, 32'(error), 0);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    int cnt;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; load_done = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_values("reset");
    do_reset();

    // Reset wins over a simultaneous byte transfer
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h03;
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    check_reset_values("rst_prio_byte");

    // Two records, load_done three cycles later
    do_reset();
    frame_q = '{8'h02, 8'h10, 8'h2A, 8'h11, 8'h18};
`ifdef LOADER_CHECKSUM_EN
    append_cs(1'b0);
`endif
    model_frame();
    send_frame(0);
`ifndef LOADER_CHECKSUM_EN
    check("strobe_latency", 32'(prog_write_enable), 1);
    check("strobe_addr", 32'(prog_addr), 17);
    check("strobe_data", 32'(prog_data_in), 24);
`endif
    finish_frame("two_rec", 3);
    if (obs_q.size() == 2) begin
      check("two_rec_w0", 32'(obs_q[0]), 32'({5'd16, 8'd42}));
      check("two_rec_w1", 32'(obs_q[1]), 32'({5'd17, 8'd24}));
    end

    // Out-of-range address
    do_reset();
    frame_q = '{8'h01, 8'h20, 8'h55};
    model_frame();
    send_frame(0);
    finish_frame("bad_addr", 0);

    // Empty frame
    do_reset();
    frame_q = '{8'h00};
`ifdef LOADER_CHECKSUM_EN
    append_cs(1'b0);
`endif
    model_frame();
    send_frame(0);
    finish_frame("empty", 7);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    frame_q = '{8'h01, 8'h10, 8'h2A, 8'h3B};
    model_frame();
    send_frame(0);
    finish_frame("cs_good", 2);
    do_reset();
    frame_q = '{8'h01, 8'h10, 8'h2A, 8'h3C};
    model_frame();
    send_frame(0);
    finish_frame("cs_bad", 0);
`endif

    // Timeout: load_done never arrives
    do_reset();
    frame_q = '{8'h01, 8'h03, 8'h99};
`ifdef LOADER_CHECKSUM_EN
    append_cs(1'b0);
`endif
    model_frame();
    send_frame(0);
    settle();
    cnt = 0;
    for (int w = 0; w < 400; w++) begin
      if (error) break;
      if (busy && !in_ready && !prog_write_enable) cnt++;
      @(negedge clock);
    end
    check("timeout_cycles", 32'(cnt), 32'(TMO));
    check("timeout_error", 32'(error), 1);
    check("timeout_start", 32'(start_execution), 0);

    // load_done on the final permitted cycle still starts
    do_reset();
    send_frame(0);
    settle();
    repeat (TMO - 1) @(negedge clock);
    load_done = 1'b1;
    @(negedge clock);
    load_done = 1'b0;
    check("timeout_edge_start", 32'(start_execution), 1);
    check("timeout_edge_error", 32'(error), 0);

    // Reset wins over simultaneous load_done
    do_reset();
    send_frame(0);
    settle();
    @(negedge clock);
    reset = 1'b1; load_done = 1'b1;
    @(negedge clock);
    reset = 1'b0; load_done = 1'b0;
    check_reset_values("rst_prio_done");

    // Same frame with in_valid toggling every other cycle
    do_reset();
    frame_q = '{8'h02, 8'h10, 8'h2A, 8'h11, 8'h18};
`ifdef LOADER_CHECKSUM_EN
    append_cs(1'b0);
`endif
    model_frame();
    send_frame(1);
    finish_frame("toggle", 1);

    // Reset after a complete record plus a lone address byte
    do_reset();
    frame_q = '{8'h02, 8'h05, 8'h77, 8'h06};
    send_frame(0);
    repeat (2) @(negedge clock);
    check("partial_nwrites", 32'(obs_q.size()), 1);
    check("partial_hold_addr", 32'(prog_addr), 5);
    check("partial_hold_data", 32'(prog_data_in), 32'h77);
    check("partial_busy", 32'(busy), 1);
    do_reset();
    check_reset_values("partial_rst");
    repeat (3) @(negedge clock);
    check("partial_nostrobe", 32'(obs_q.size()), 0);

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      do_reset();
      build_random();
      send_frame($urandom_range(0, 2));
      finish_frame("rand", $urandom_range(0, 10));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
